// File: rtl/drive_controller.sv
// Two-channel H-bridge drive controller.
// Channel A drives the right motor and channel B drives the left motor. One PWM
// counter is shared, with two duty levels (full, veer) clamped to a ceiling.
// The controller handles forward and reverse travel, with a braked dead-time
// before every polarity reversal. It also runs a timed back-up after a
// collision and a timed pause at junctions.
// Interface: there is no valid/ready handshake. dir, colDetect and reverseMode
// are level inputs sampled on every rising clock edge. Every output is a
// registered image of the counter and state from the previous cycle. The
// state output shows the FSM code of that same previous cycle.
module drive_controller #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned PWM_FREQ      = 80,
  parameter int unsigned FULL_PCT      = 80,
  parameter int unsigned VEER_PCT      = 40,
  parameter int unsigned MAX_PCT       = 80,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned DEAD_CYCLES   = 50_000,
  parameter int unsigned BACKUP_CYCLES = 25_000_000,
  parameter int unsigned JUNC_CYCLES   = 25_000_000,
  parameter int unsigned TMR_W         = 26
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [3:0] dir,
  input  logic       colDetect,
  input  logic       reverseMode,
  output logic       hbEnA,
  output logic       hbEnB,
  output logic       hbIn1,
  output logic       hbIn2,
  output logic       hbIn3,
  output logic       hbIn4,
  output logic [2:0] state,
  output logic       pwmSync
);

  // PWM on-counts are computed in 64 bits and truncated. A 0% duty gives an
  // on-count of 0, so the enable stays low.
  localparam longint unsigned PERIOD    = longint'(CLK_HZ / PWM_FREQ);
  localparam longint unsigned FULL_EFF  = (FULL_PCT < MAX_PCT) ? FULL_PCT : MAX_PCT;
  localparam longint unsigned VEER_EFF  = (VEER_PCT < MAX_PCT) ? VEER_PCT : MAX_PCT;
  localparam longint unsigned FULL_ON   = (PERIOD * FULL_EFF) / 100;
  localparam longint unsigned VEER_ON   = (PERIOD * VEER_EFF) / 100;
  localparam logic [CNT_W:0]   FULL_ON_C = FULL_ON[CNT_W:0];
  localparam logic [CNT_W:0]   VEER_ON_C = VEER_ON[CNT_W:0];
  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [TMR_W-1:0] DEAD_LD   = TMR_W'(DEAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] BACKUP_LD = TMR_W'(BACKUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] JUNC_LD   = TMR_W'(JUNC_CYCLES - 1);

  // Polarity patterns, packed as {In1, In2, In3, In4}.
  localparam logic [3:0] POL_FWD   = 4'b0110;
  localparam logic [3:0] POL_REV   = 4'b1001;
  localparam logic [3:0] POL_BRAKE = 4'b0000;

  typedef enum logic [2:0] {
    S_DEAD   = 3'd0,
    S_FWD    = 3'd1,
    S_REV    = 3'd2,
    S_COLL   = 3'd3,
    S_BACKUP = 3'd4,
    S_JUNC   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_dec;
  logic             travel_q, travel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_full, pwm_veer;
  logic             en_a_q, en_a_d, en_b_q, en_b_d;
  logic [3:0]       pol_q, pol_d;
  logic [2:0]       state_out_q, state_out_d;
  logic             sync_q, sync_d;
  logic             dir_unused;

  assign dir_unused = ^dir[1:0];

  // Shared PWM timebase and the two duty comparators.
  always_comb begin
    cnt_d    = (cnt_q == PERIOD_M1) ? '0 : cnt_q + 1'b1;
    pwm_full = ({1'b0, cnt_q} < FULL_ON_C);
    pwm_veer = ({1'b0, cnt_q} < VEER_ON_C);
    sync_d   = (cnt_q == '0);
  end

  // Next-state, timer and travel-direction logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    travel_d  = travel_q;
    timer_dec = (timer_q == '0) ? '0 : timer_q - 1'b1;
    case (state_q)
      S_DEAD: begin
        if (timer_q == '0) state_d = travel_q ? S_REV : S_FWD;
        else               timer_d = timer_dec;
      end
      S_FWD, S_REV: begin
        if (colDetect) begin
          state_d = S_COLL;
          timer_d = DEAD_LD;
        end else if (reverseMode != travel_q) begin
          travel_d = reverseMode;
          state_d  = S_DEAD;
          timer_d  = DEAD_LD;
        end else if (dir[3:2] == 2'b11) begin
          state_d = S_JUNC;
          timer_d = JUNC_LD;
        end
      end
      S_COLL: begin
        if (!colDetect && timer_q == '0) begin
          state_d = S_BACKUP;
          timer_d = BACKUP_LD;
        end else begin
          timer_d = timer_dec;
        end
      end
      S_BACKUP: begin
        if (colDetect) begin
          state_d = S_COLL;
          timer_d = DEAD_LD;
        end else if (timer_q == '0) begin
          state_d = S_DEAD;
          timer_d = DEAD_LD;
        end else begin
          timer_d = timer_dec;
        end
      end
      S_JUNC: begin
        // The bridge is already braked here, so leaving goes straight to
        // travel in the latched direction.
        if (colDetect) begin
          state_d = S_COLL;
          timer_d = DEAD_LD;
        end else if (timer_q == '0 && dir[3:2] != 2'b11) begin
          travel_d = reverseMode;
          state_d  = reverseMode ? S_REV : S_FWD;
        end else begin
          timer_d = timer_dec;
        end
      end
      default: begin
        state_d = S_DEAD;
        timer_d = DEAD_LD;
      end
    endcase
  end

  // Bridge drive for the current state. Steering is mirrored in reverse
  // because the motors swap sides relative to the direction of travel.
  always_comb begin
    en_a_d      = 1'b0;
    en_b_d      = 1'b0;
    pol_d       = POL_BRAKE;
    state_out_d = state_q;
    case (state_q)
      S_FWD: begin
        pol_d = POL_FWD;
        case (dir[3:2])
          2'b00:   begin en_a_d = pwm_full; en_b_d = pwm_full; end
          2'b01:   begin en_a_d = pwm_veer; en_b_d = pwm_full; end
          2'b10:   begin en_a_d = pwm_full; en_b_d = pwm_veer; end
          default: ;
        endcase
      end
      S_REV: begin
        pol_d = POL_REV;
        case (dir[3:2])
          2'b00:   begin en_a_d = pwm_full; en_b_d = pwm_full; end
          2'b01:   begin en_a_d = pwm_full; en_b_d = pwm_veer; end
          2'b10:   begin en_a_d = pwm_veer; en_b_d = pwm_full; end
          default: ;
        endcase
      end
      S_BACKUP: begin
        pol_d  = travel_q ? POL_FWD : POL_REV;
        en_a_d = pwm_veer;
        en_b_d = pwm_veer;
      end
      default: ;
    endcase
  end

  // State, timer, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= S_DEAD;
      timer_q     <= DEAD_LD;
      travel_q    <= 1'b0;
      cnt_q       <= '0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      pol_q       <= POL_BRAKE;
      state_out_q <= 3'd0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      travel_q    <= travel_d;
      cnt_q       <= cnt_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      pol_q       <= pol_d;
      state_out_q <= state_out_d;
      sync_q      <= sync_d;
    end
  end

  assign hbEnA   = en_a_q;
  assign hbEnB   = en_b_q;
  assign hbIn1   = pol_q[3];
  assign hbIn2   = pol_q[2];
  assign hbIn3   = pol_q[1];
  assign hbIn4   = pol_q[0];
  assign state   = state_out_q;
  assign pwmSync = sync_q;

endmodule

// File: doc/drive_controller.md
Name: drive_controller

Overview:
- Parametrised successor to the single-direction H-bridge drive FSM.
- Drives two H-bridge channels (A = right motor, B = left motor) using one shared PWM timebase and two clamped duty levels (full, veer).
- Adds reverse-track travel, polarity dead-time, a timed collision back-up, and a timed junction pause.
- Sits between the direction-control decoder and the H-bridge pins.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- PWM_FREQ, 80, PWM frequency in Hz; PERIOD = CLK_HZ/PWM_FREQ.
- FULL_PCT, 80, full-speed duty in percent.
- VEER_PCT, 40, veer and back-up duty in percent.
- MAX_PCT, 80, H-bridge duty ceiling; FULL_PCT and VEER_PCT are clamped to it.
- CNT_W, 20, PWM counter width; PERIOD must be ≤ 2^CNT_W.
- DEAD_CYCLES, 50_000, brake cycles before any polarity reversal (≥1).
- BACKUP_CYCLES, 25_000_000, back-up duration after a collision clears (≥1).
- JUNC_CYCLES, 25_000_000, minimum pause at a junction (≥1).
- TMR_W, 26, width of the state timer.

Ports:
- clk  in  1  system clock.
- rstN  in  1  synchronous active-low reset, sampled on posedge clk.
- dir  in  4  direction-control code; dir[3:2]: 00 straight, 01 left, 10 right, 11 junction/stop; dir[1:0] unused.
- colDetect  in  1  collision present, level-sensitive.
- reverseMode  in  1  0 = travel track forwards, 1 = travel track backwards.
- hbEnA, hbEnB  out  1 each  H-bridge enables, PWM-gated.
- hbIn1, hbIn2, hbIn3, hbIn4  out  1 each  H-bridge polarity inputs.
- state  out  3  current FSM state code.
- pwmSync  out  1  one-cycle pulse when the PWM counter is 0.

Behaviour:
- Reset (rstN=0 at posedge):
  - All hb* outputs 0, pwmSync 0, PWM counter 0.
  - state = DEAD, timer = DEAD_CYCLES-1, travel = 0.
- PWM:
  - Counter runs 0..PERIOD-1 and wraps to 0.
  - ON counts: FULL_ON = PERIOD*min(FULL_PCT,MAX_PCT)/100 and VEER_ON = PERIOD*min(VEER_PCT,MAX_PCT)/100; compute in ≥32-bit, truncating.
  - pwmFull = (cnt < FULL_ON); pwmVeer = (cnt < VEER_ON).
  - A duty of 0% gives a constant 0.
- Output timing: all outputs are registered, one cycle after the counter/state they reflect.
- Polarity patterns (In1..In4):
  - FWD = 0,1,1,0.
  - REV = 1,0,0,1.
  - BRAKE = 0,0,0,0 with both enables 0.
- State codes: DEAD=0, FWD=1, REV=2, COLL=3, BACKUP=4, JUNC=5.
- DEAD:
  - Outputs BRAKE; timer decrements each cycle.
  - When timer==0, go to FWD if travel=0, else REV. Occupancy is exactly DEAD_CYCLES cycles.
- FWD/REV, priority order:
  1. colDetect → COLL, timer = DEAD_CYCLES-1.
  2. reverseMode≠travel → latch travel = reverseMode, go to DEAD, timer = DEAD_CYCLES-1.
  3. dir[3:2]=11 → JUNC, timer = JUNC_CYCLES-1.
  4. Otherwise steer:
     - 00: EnA = EnB = pwmFull.
     - 01 in FWD: EnA = pwmVeer, EnB = pwmFull.
     - 10 in FWD: EnA = pwmFull, EnB = pwmVeer.
     - In REV, 01 and 10 are mirrored.
     - Polarity is FWD in FWD and REV in REV.
- COLL:
  - Outputs BRAKE; timer decrements and saturates at 0.
  - When colDetect=0 and timer==0 → BACKUP, timer = BACKUP_CYCLES-1.
  - colDetect held keeps COLL indefinitely.
- BACKUP:
  - Polarity is opposite to travel; both enables = pwmVeer.
  - colDetect=1 → COLL, timer = DEAD_CYCLES-1.
  - When timer==0 → DEAD, timer = DEAD_CYCLES-1 (polarity flips back).
- JUNC:
  - Outputs BRAKE.
  - colDetect=1 → COLL.
  - When timer==0 and dir[3:2]≠11 → FWD/REV per travel, with no dead-time (the inputs are already 0).
  - A reverseMode change while in JUNC is latched into travel on exit.
- Invariants:
  - hbIn1&hbIn2 and hbIn3&hbIn4 are never 1.
  - Polarity never changes between FWD and REV patterns without ≥DEAD_CYCLES BRAKE cycles in between.
- Reset mid-operation: rstN=0 in any state gives outputs 0 on the next cycle and restarts at DEAD.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=1000, PWM_FREQ=10 (PERIOD=100), FULL_PCT=80, VEER_PCT=40, DEAD=4, BACKUP=20, JUNC=10.
- Reset, reverseMode=0, dir=0000 → BRAKE for 4 cycles, then In=0110, and EnA/EnB high exactly 80 of every 100 cycles; pwmSync pulses every 100 cycles.
- FULL_PCT=95 → duty clamps to 80/100. dir=0100 in FWD → EnA high 40/100, EnB high 80/100. Same code in REV → EnA 80/100, EnB 40/100.
- In FWD, toggle reverseMode to 1 → ≥4 cycles of In=0000 and En=0, then In=1001; no cycle with both 0110 and 1001 adjacent.
- colDetect high for 7 cycles then low → COLL (state=3) for 7 cycles, BACKUP for 20 cycles with In=1001 and En duty 40%, DEAD for 4 cycles, then FWD.
- dir=1100 for 3 cycles then 0000 → JUNC held 10 cycles, then FWD. colDetect pulsed during BACKUP → immediate COLL with timer reloaded.
- rstN low for 1 cycle while in BACKUP → all outputs 0 next cycle, state=0, PWM counter 0.
